// File: rtl/calc_ctrl.sv
// Keypad calculator sequencer: operand entry, ALU start/done handshake, display source and error/abort recovery.
// Every output is registered and reacts in the cycle after the key_valid or alu_done that caused it.
module calc_ctrl #(
    parameter int unsigned MAX_DIGITS  = 4,
    parameter int unsigned ALU_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [1:0] key_class,
    input  logic [1:0] key_op,
    input  logic       alu_done,
    input  logic       alu_err,
    output logic       op1_load,
    output logic       op2_load,
    output logic       op1_clear,
    output logic       op2_clear,
    output logic       op1_from_result,
    output logic       alu_start,
    output logic [1:0] alu_op,
    output logic [1:0] disp_sel,
    output logic [2:0] digit_count,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ENTER_A  = 3'd0,
        ENTER_B  = 3'd1,
        EXEC     = 3'd2,
        SHOW_RES = 3'd3,
        ERROR    = 3'd4
    } state_t;

    localparam int unsigned      TW       = $clog2(ALU_TIMEOUT) + 1;
    localparam logic [TW-1:0]    TMO_LAST = TW'(ALU_TIMEOUT - 1);
    localparam logic [2:0]       MAXD     = 3'(MAX_DIGITS);
    localparam logic [1:0]       D_OP1    = 2'd0;
    localparam logic [1:0]       D_OP2    = 2'd1;
    localparam logic [1:0]       D_RES    = 2'd2;
    localparam logic [1:0]       D_ERR    = 2'd3;

    state_t        state_q;
    logic          op1_load_q, op2_load_q, op1_clear_q, op2_clear_q;
    logic          op1_from_result_q, alu_start_q, busy_q, chain_q;
    logic [1:0]    alu_op_q, pend_op_q, disp_q;
    logic [2:0]    cnt_q;
    logic [TW-1:0] tmo_q;

    logic is_dig, is_op, is_eq, is_clr, room;

    assign is_dig = key_valid && (key_class == 2'd0);
    assign is_op  = key_valid && (key_class == 2'd1);
    assign is_eq  = key_valid && (key_class == 2'd2);
    assign is_clr = key_valid && (key_class == 2'd3);
    assign room   = (cnt_q < MAXD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ENTER_A;
            op1_load_q        <= 1'b0;
            op2_load_q        <= 1'b0;
            op1_clear_q       <= 1'b0;
            op2_clear_q       <= 1'b0;
            op1_from_result_q <= 1'b0;
            alu_start_q       <= 1'b0;
            busy_q            <= 1'b0;
            chain_q           <= 1'b0;
            alu_op_q          <= 2'd0;
            pend_op_q         <= 2'd0;
            disp_q            <= D_OP1;
            cnt_q             <= 3'd0;
            tmo_q             <= '0;
        end else begin
            op1_load_q        <= 1'b0;
            op2_load_q        <= 1'b0;
            op1_clear_q       <= 1'b0;
            op2_clear_q       <= 1'b0;
            op1_from_result_q <= 1'b0;
            alu_start_q       <= 1'b0;
            // Clear outranks everything, including an alu_done landing in the same cycle.
            if (is_clr) begin
                op1_clear_q <= 1'b1;
                op2_clear_q <= 1'b1;
                cnt_q       <= 3'd0;
                chain_q     <= 1'b0;
                busy_q      <= 1'b0;
                disp_q      <= D_OP1;
                state_q     <= ENTER_A;
            end else begin
                case (state_q)
                    ENTER_A: begin
                        if (is_dig && room) begin
                            op1_load_q <= 1'b1;
                            cnt_q      <= cnt_q + 3'd1;
                        end else if (is_op) begin
                            alu_op_q    <= key_op;
                            op2_clear_q <= 1'b1;
                            cnt_q       <= 3'd0;
                            disp_q      <= D_OP1;
                            state_q     <= ENTER_B;
                        end
                    end
                    ENTER_B: begin
                        if (is_dig && room) begin
                            op2_load_q <= 1'b1;
                            cnt_q      <= cnt_q + 3'd1;
                            disp_q     <= D_OP2;
                        end else if (is_op && cnt_q == 3'd0) begin
                            alu_op_q <= key_op;
                        end else if ((is_op || is_eq) && cnt_q != 3'd0) begin
                            alu_start_q <= 1'b1;
                            chain_q     <= is_op;
                            if (is_op) pend_op_q <= key_op;
                            busy_q      <= 1'b1;
                            tmo_q       <= '0;
                            state_q     <= EXEC;
                        end
                    end
                    EXEC: begin
                        if (alu_done) begin
                            busy_q <= 1'b0;
                            if (alu_err) begin
                                disp_q  <= D_ERR;
                                state_q <= ERROR;
                            end else begin
                                op1_from_result_q <= 1'b1;
                                if (chain_q) begin
                                    // Result becomes operand 1 and entry resumes on operand 2.
                                    alu_op_q    <= pend_op_q;
                                    op2_clear_q <= 1'b1;
                                    cnt_q       <= 3'd0;
                                    chain_q     <= 1'b0;
                                    disp_q      <= D_OP1;
                                    state_q     <= ENTER_B;
                                end else begin
                                    disp_q  <= D_RES;
                                    state_q <= SHOW_RES;
                                end
                            end
                        end else if (tmo_q == TMO_LAST) begin
                            busy_q  <= 1'b0;
                            disp_q  <= D_ERR;
                            state_q <= ERROR;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    SHOW_RES: begin
                        if (is_dig) begin
                            op1_clear_q <= 1'b1;
                            op1_load_q  <= 1'b1;
                            cnt_q       <= 3'd1;
                            disp_q      <= D_OP1;
                            state_q     <= ENTER_A;
                        end else if (is_op) begin
                            alu_op_q    <= key_op;
                            op2_clear_q <= 1'b1;
                            cnt_q       <= 3'd0;
                            disp_q      <= D_OP1;
                            state_q     <= ENTER_B;
                        end
                    end
                    ERROR: ;
                    default: begin
                        busy_q  <= 1'b0;
                        disp_q  <= D_ERR;
                        state_q <= ERROR;
                    end
                endcase
            end
        end
    end

    assign op1_load        = op1_load_q;
    assign op2_load        = op2_load_q;
    assign op1_clear       = op1_clear_q;
    assign op2_clear       = op2_clear_q;
    assign op1_from_result = op1_from_result_q;
    assign alu_start       = alu_start_q;
    assign alu_op          = alu_op_q;
    assign disp_sel        = disp_q;
    assign digit_count     = cnt_q;
    assign busy            = busy_q;
    assign state           = state_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Scoreboard bench for calc_ctrl: each driven cycle queues the expected registered outputs for the following edge.
module tb_calc_ctrl;

    localparam int MAXD = 4;
    localparam int TMO  = 64;

    localparam logic [1:0] K_DIG = 2'd0, K_OP = 2'd1, K_EQ = 2'd2, K_CLR = 2'd3;
    localparam logic [1:0] OP_ADD = 2'd1, OP_SUB = 2'd2, OP_DIV = 2'd3;
    localparam logic [2:0] S_A = 3'd0, S_B = 3'd1, S_X = 3'd2, S_S = 3'd3, S_E = 3'd4;
    // Pulse vector order: {alu_start, op1_from_result, op2_clear, op1_clear, op2_load, op1_load}
    localparam logic [5:0] P_NO = 6'b000000, P_L1 = 6'b000001, P_L2 = 6'b000010,
                           P_C1 = 6'b000100, P_C2 = 6'b001000, P_FR = 6'b010000,
                           P_ST = 6'b100000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [1:0] key_class = 2'd0;
    logic [1:0] key_op = 2'd0;
    logic       alu_done = 1'b0;
    logic       alu_err = 1'b0;
    logic       op1_load, op2_load, op1_clear, op2_clear, op1_from_result, alu_start, busy;
    logic [1:0] alu_op, disp_sel;
    logic [2:0] digit_count, state;

    typedef struct {
        int         idx;
        logic [5:0] p;
        logic [2:0] st;
        logic [2:0] cnt;
        logic [1:0] disp;
        logic [1:0] op;
        logic       b;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_step = 0;

    calc_ctrl #(.MAX_DIGITS(MAXD), .ALU_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_class(key_class), .key_op(key_op),
        .alu_done(alu_done), .alu_err(alu_err), .op1_load(op1_load), .op2_load(op2_load),
        .op1_clear(op1_clear), .op2_clear(op2_clear), .op1_from_result(op1_from_result),
        .alu_start(alu_start), .alu_op(alu_op), .disp_sel(disp_sel), .digit_count(digit_count),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check($sformatf("s%0d.pulse", mon_e.idx),
                  {2'b00, alu_start, op1_from_result, op2_clear, op1_clear, op2_load, op1_load},
                  {2'b00, mon_e.p});
            check($sformatf("s%0d.state", mon_e.idx), {5'd0, state}, {5'd0, mon_e.st});
            check($sformatf("s%0d.count", mon_e.idx), {5'd0, digit_count}, {5'd0, mon_e.cnt});
            check($sformatf("s%0d.disp", mon_e.idx), {6'd0, disp_sel}, {6'd0, mon_e.disp});
            check($sformatf("s%0d.aluop", mon_e.idx), {6'd0, alu_op}, {6'd0, mon_e.op});
            check($sformatf("s%0d.busy", mon_e.idx), {7'd0, busy}, {7'd0, mon_e.b});
        end
    end

    task automatic step(input logic r, input logic kv, input logic [1:0] kc, input logic [1:0] kop,
                        input logic dn, input logic er, input logic [5:0] p, input logic [2:0] st,
                        input logic [2:0] cnt, input logic [1:0] disp, input logic [1:0] op,
                        input logic b);
        exp_t e;
        @(negedge clk);
        rst = r; key_valid = kv; key_class = kc; key_op = kop; alu_done = dn; alu_err = er;
        e.idx = n_step; e.p = p; e.st = st; e.cnt = cnt; e.disp = disp; e.op = op; e.b = b;
        n_step++;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic key(input logic [1:0] kc, input logic [1:0] kop, input logic [5:0] p,
                       input logic [2:0] st, input logic [2:0] cnt, input logic [1:0] disp,
                       input logic [1:0] op, input logic b);
        step(1'b0, 1'b1, kc, kop, 1'b0, 1'b0, p, st, cnt, disp, op, b);
    endtask

    task automatic idle(input logic [5:0] p, input logic [2:0] st, input logic [2:0] cnt,
                        input logic [1:0] disp, input logic [1:0] op, input logic b);
        step(1'b0, 1'b0, K_DIG, 2'd0, 1'b0, 1'b0, p, st, cnt, disp, op, b);
    endtask

    task automatic done(input logic er, input logic [5:0] p, input logic [2:0] st,
                        input logic [2:0] cnt, input logic [1:0] disp, input logic [1:0] op,
                        input logic b);
        step(1'b0, 1'b0, K_DIG, 2'd0, 1'b1, er, p, st, cnt, disp, op, b);
    endtask

    initial begin
        // Reset with a key in the same cycle: the key is discarded.
        step(1'b1, 1'b1, K_DIG, 2'd0, 1'b0, 1'b0, P_NO, S_A, 3'd0, 2'd0, 2'd0, 1'b0);
        idle(P_NO, S_A, 3'd0, 2'd0, 2'd0, 1'b0);

        // 1 2 + 3 = with alu_done four cycles after alu_start
        key(K_DIG, 2'd0, P_L1, S_A, 3'd1, 2'd0, 2'd0, 1'b0);
        key(K_DIG, 2'd0, P_L1, S_A, 3'd2, 2'd0, 2'd0, 1'b0);
        key(K_EQ,  2'd0, P_NO, S_A, 3'd2, 2'd0, 2'd0, 1'b0);
        key(K_OP,  OP_ADD, P_C2, S_B, 3'd0, 2'd0, OP_ADD, 1'b0);
        key(K_DIG, 2'd0, P_L2, S_B, 3'd1, 2'd1, OP_ADD, 1'b0);
        key(K_EQ,  2'd0, P_ST, S_X, 3'd1, 2'd1, OP_ADD, 1'b1);
        for (int i = 0; i < 3; i++) idle(P_NO, S_X, 3'd1, 2'd1, OP_ADD, 1'b1);
        done(1'b0, P_FR, S_S, 3'd1, 2'd2, OP_ADD, 1'b0);
        idle(P_NO, S_S, 3'd1, 2'd2, OP_ADD, 1'b0);

        // Digit after a result restarts operand 1
        key(K_DIG, 2'd0, P_C1 | P_L1, S_A, 3'd1, 2'd0, OP_ADD, 1'b0);
        idle(P_NO, S_A, 3'd1, 2'd0, OP_ADD, 1'b0);

        // Five digits with room for four
        key(K_CLR, 2'd0, P_C1 | P_C2, S_A, 3'd0, 2'd0, OP_ADD, 1'b0);
        for (int i = 1; i <= MAXD; i++) key(K_DIG, 2'd0, P_L1, S_A, 3'(i), 2'd0, OP_ADD, 1'b0);
        key(K_DIG, 2'd0, P_NO, S_A, 3'(MAXD), 2'd0, OP_ADD, 1'b0);

        // Chain 5 + 3 - 2 =, with op replacement and an early equals in ENTER_B
        key(K_CLR, 2'd0, P_C1 | P_C2, S_A, 3'd0, 2'd0, OP_ADD, 1'b0);
        key(K_DIG, 2'd0, P_L1, S_A, 3'd1, 2'd0, OP_ADD, 1'b0);
        key(K_OP,  OP_ADD, P_C2, S_B, 3'd0, 2'd0, OP_ADD, 1'b0);
        key(K_OP,  OP_DIV, P_NO, S_B, 3'd0, 2'd0, OP_DIV, 1'b0);
        key(K_OP,  OP_ADD, P_NO, S_B, 3'd0, 2'd0, OP_ADD, 1'b0);
        key(K_EQ,  2'd0, P_NO, S_B, 3'd0, 2'd0, OP_ADD, 1'b0);
        key(K_DIG, 2'd0, P_L2, S_B, 3'd1, 2'd1, OP_ADD, 1'b0);
        key(K_OP,  OP_SUB, P_ST, S_X, 3'd1, 2'd1, OP_ADD, 1'b1);
        idle(P_NO, S_X, 3'd1, 2'd1, OP_ADD, 1'b1);
        done(1'b0, P_FR | P_C2, S_B, 3'd0, 2'd0, OP_SUB, 1'b0);
        key(K_DIG, 2'd0, P_L2, S_B, 3'd1, 2'd1, OP_SUB, 1'b0);
        key(K_EQ,  2'd0, P_ST, S_X, 3'd1, 2'd1, OP_SUB, 1'b1);
        done(1'b0, P_FR, S_S, 3'd1, 2'd2, OP_SUB, 1'b0);

        // Divide by zero from SHOW_RES, keys ignored in EXEC and ERROR
        key(K_OP,  OP_DIV, P_C2, S_B, 3'd0, 2'd0, OP_DIV, 1'b0);
        key(K_DIG, 2'd0, P_L2, S_B, 3'd1, 2'd1, OP_DIV, 1'b0);
        key(K_EQ,  2'd0, P_ST, S_X, 3'd1, 2'd1, OP_DIV, 1'b1);
        key(K_DIG, 2'd0, P_NO, S_X, 3'd1, 2'd1, OP_DIV, 1'b1);
        done(1'b1, P_NO, S_E, 3'd1, 2'd3, OP_DIV, 1'b0);
        key(K_DIG, 2'd0, P_NO, S_E, 3'd1, 2'd3, OP_DIV, 1'b0);
        key(K_OP,  OP_ADD, P_NO, S_E, 3'd1, 2'd3, OP_DIV, 1'b0);
        key(K_EQ,  2'd0, P_NO, S_E, 3'd1, 2'd3, OP_DIV, 1'b0);
        done(1'b0, P_NO, S_E, 3'd1, 2'd3, OP_DIV, 1'b0);
        key(K_CLR, 2'd0, P_C1 | P_C2, S_A, 3'd0, 2'd0, OP_DIV, 1'b0);

        // No alu_done: exactly TMO cycles in EXEC, then ERROR
        key(K_DIG, 2'd0, P_L1, S_A, 3'd1, 2'd0, OP_DIV, 1'b0);
        key(K_OP,  OP_ADD, P_C2, S_B, 3'd0, 2'd0, OP_ADD, 1'b0);
        key(K_DIG, 2'd0, P_L2, S_B, 3'd1, 2'd1, OP_ADD, 1'b0);
        key(K_EQ,  2'd0, P_ST, S_X, 3'd1, 2'd1, OP_ADD, 1'b1);
        for (int i = 1; i < TMO; i++) idle(P_NO, S_X, 3'd1, 2'd1, OP_ADD, 1'b1);
        idle(P_NO, S_E, 3'd1, 2'd3, OP_ADD, 1'b0);
        key(K_CLR, 2'd0, P_C1 | P_C2, S_A, 3'd0, 2'd0, OP_ADD, 1'b0);

        // alu_done on the expiry cycle wins over the timeout
        key(K_DIG, 2'd0, P_L1, S_A, 3'd1, 2'd0, OP_ADD, 1'b0);
        key(K_OP,  OP_SUB, P_C2, S_B, 3'd0, 2'd0, OP_SUB, 1'b0);
        key(K_DIG, 2'd0, P_L2, S_B, 3'd1, 2'd1, OP_SUB, 1'b0);
        key(K_EQ,  2'd0, P_ST, S_X, 3'd1, 2'd1, OP_SUB, 1'b1);
        for (int i = 1; i < TMO; i++) idle(P_NO, S_X, 3'd1, 2'd1, OP_SUB, 1'b1);
        done(1'b0, P_FR, S_S, 3'd1, 2'd2, OP_SUB, 1'b0);

        // Clear and alu_done in the same cycle: clear wins, no result copy
        key(K_OP,  OP_ADD, P_C2, S_B, 3'd0, 2'd0, OP_ADD, 1'b0);
        key(K_DIG, 2'd0, P_L2, S_B, 3'd1, 2'd1, OP_ADD, 1'b0);
        key(K_EQ,  2'd0, P_ST, S_X, 3'd1, 2'd1, OP_ADD, 1'b1);
        step(1'b0, 1'b1, K_CLR, 2'd0, 1'b1, 1'b0, P_C1 | P_C2, S_A, 3'd0, 2'd0, OP_ADD, 1'b0);
        idle(P_NO, S_A, 3'd0, 2'd0, OP_ADD, 1'b0);

        // Reset mid-EXEC aborts silently; a late alu_done is ignored
        key(K_DIG, 2'd0, P_L1, S_A, 3'd1, 2'd0, OP_ADD, 1'b0);
        key(K_OP,  OP_DIV, P_C2, S_B, 3'd0, 2'd0, OP_DIV, 1'b0);
        key(K_DIG, 2'd0, P_L2, S_B, 3'd1, 2'd1, OP_DIV, 1'b0);
        key(K_EQ,  2'd0, P_ST, S_X, 3'd1, 2'd1, OP_DIV, 1'b1);
        step(1'b1, 1'b0, K_DIG, 2'd0, 1'b0, 1'b0, P_NO, S_A, 3'd0, 2'd0, 2'd0, 1'b0);
        done(1'b0, P_NO, S_A, 3'd0, 2'd0, 2'd0, 1'b0);
        idle(P_NO, S_A, 3'd0, 2'd0, 2'd0, 1'b0);

        @(negedge clk);
        key_valid = 1'b0; alu_done = 1'b0; rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("sb_drained", 8'(sb.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
